// File: rtl/uart_tx_if.sv
// Byte handshake between the transfer handler (master) and the UART transmit engine (slave).
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, tx_valid, input  tx_ready);
  modport slave  (input  tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity, STOP_BITS stop bits.
// The parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int W_BAUD       = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic     clk,
  input  logic     rstn,
  uart_tx_if.slave txi,
  output logic     tx,
  output logic     busy,
  output logic     done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [W_BAUD-1:0] BAUD_LAST = W_BAUD'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  state_t            state_q, state_nx;
  logic [W_BAUD-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic              stop_q;
  logic [7:0]        shift_q;
  logic              tx_nx;
  logic              accept;
  logic              bit_end;

  assign bit_end      = (baud_q == BAUD_LAST);
  assign txi.tx_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic par_q;

  // Parity is taken at capture time because the shift register is consumed as bits go out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       par_q <= 1'b0;
    else if (accept) par_q <= ^txi.tx_data ^ PAR_SENSE;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      tx        <= 1'b1;
    end else begin
      state_q <= state_nx;
      tx      <= tx_nx;
      if (state_q == IDLE || bit_end) baud_q <= '0;
      else                            baud_q <= baud_q + 1'b1;
      if (accept) begin
        shift_q   <= txi.tx_data;
        bit_idx_q <= '0;
        stop_q    <= 1'b0;
      end else if (bit_end) begin
        if (state_q == DATA) begin
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
        end
        if (state_q == STOP) stop_q <= ~stop_q;
      end
    end
  end

  // tx is registered, so tx_nx is the level of the bit being entered on this edge.
  always_comb begin
    state_nx = state_q;
    tx_nx    = tx;
    accept   = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_nx = 1'b1;
        if (txi.tx_valid) begin
          accept   = 1'b1;
          state_nx = START;
          tx_nx    = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_nx = DATA;
        tx_nx    = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nx = PARITY;
          tx_nx    = par_q;
`else
          state_nx = STOP;
          tx_nx    = 1'b1;
`endif
        end else begin
          tx_nx = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_nx = STOP;
        tx_nx    = 1'b1;
      end
`endif
      STOP: if (bit_end && stop_q == STOP_LAST) begin
        done     = 1'b1;
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

endmodule
